serial_encode: RTL

//   Transmit side of the thermostat serial link: serializes one 192-bit frame per start request.

---
 rtl/serial_encode.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_encode.sv
// Thermostat serial-link transmitter: shifts out one 192-bit frame (96-bit header + 96-bit payload)
// MSB first, one bit per serial_clock, followed by a configurable idle gap before busy drops.
module serial_encode #(
    parameter logic [31:0] PREAMBLE   = 32'hAAAA_AAAA,
    parameter logic [15:0] TYPE_1     = 16'h0001,
    parameter logic [15:0] TYPE_2     = 16'h0001,
    parameter logic [31:0] CONSTANT   = 32'h5555_5555,
    parameter int          GAP_BITS   = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic        serial_clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        serial_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } enc_state_t;

    localparam logic [7:0]  LAST_BIT = 8'd191;
    localparam logic [7:0]  GAP_LOAD = (GAP_BITS > 0) ? 8'(GAP_BITS - 1) : 8'd0;
    localparam logic [95:0] HEADER   = {PREAMBLE, TYPE_1, TYPE_2, CONSTANT};

    enc_state_t   state_r;
    logic [190:0] frame_r;
    logic [7:0]   cnt_r;
    logic         serial_data_r;
    logic         busy_r;
    logic         done_r;
    logic [95:0]  payload_s;
    logic [191:0] frame_load_s;

    // Assemble the frame to be latched on acceptance
    always_comb begin
        payload_s    = {thermostat_id, room_temp, set_temp, state, tail_1, tail_2, tail_3};
        frame_load_s = {HEADER, payload_s};
    end

    // Frame sequencer; bit 191 goes straight to the line, the remaining 191 bits shift out of frame_r
    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            frame_r       <= '0;
            cnt_r         <= 8'd0;
            serial_data_r <= IDLE_LEVEL;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        frame_r       <= frame_load_s[190:0];
                        serial_data_r <= frame_load_s[191];
                        busy_r        <= 1'b1;
                        cnt_r         <= LAST_BIT;
                        state_r       <= ST_SEND;
                    end else begin
                        serial_data_r <= IDLE_LEVEL;
                        busy_r        <= 1'b0;
                        cnt_r         <= 8'd0;
                    end
                end
                ST_SEND: begin
                    if (cnt_r == 8'd0) begin
                        // Bit 0 has been on the line for one cycle: close the frame
                        serial_data_r <= IDLE_LEVEL;
                        done_r        <= 1'b1;
                        if (GAP_BITS == 0) begin
                            busy_r  <= 1'b0;
                            cnt_r   <= 8'd0;
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r   <= GAP_LOAD;
                            state_r <= ST_GAP;
                        end
                    end else begin
                        frame_r       <= {frame_r[189:0], 1'b0};
                        serial_data_r <= frame_r[190];
                        cnt_r         <= cnt_r - 8'd1;
                    end
                end
                ST_GAP: begin
                    serial_data_r <= IDLE_LEVEL;
                    if (cnt_r == 8'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= 8'd0;
                    serial_data_r <= IDLE_LEVEL;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign serial_data = serial_data_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
